// File: rtl/divider_seq_ctrl.sv
// divider_seq_ctrl
// Sequential restoring divider: the controller and datapath for the Divisor design.
// It owns the {remainder, quotient} working register. Each of the WL iterations
// runs as one SHIFT cycle followed by one SUB cycle.
// The busy, shift_en and done outputs are registered copies of the state, so each
// one appears one cycle after the state it reflects. The shift-register stage
// downstream samples shift_en on that same registered timing.

module divider_seq_ctrl #(
  parameter int WL = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [WL-1:0] dividend,
  input  logic [WL-1:0] divisor,
  output logic          busy,
  output logic          shift_en,
  output logic          done,
  output logic [WL-1:0] quotient,
  output logic [WL-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(WL) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SUB,
    DONE
  } state_t;

  state_t          state;
  logic [2*WL-1:0] work;
  logic [WL-1:0]   dvsr;
  logic [CW-1:0]   iter;

  logic [WL-1:0]   upper;
  logic [WL-1:0]   upper_diff;
  logic            fits;
  logic [2*WL-1:0] work_sub;
  logic [CW-1:0]   iter_next;

  // Trial subtraction on the upper half; restore means keep the working register untouched
  always_comb begin
    upper      = work[2*WL-1:WL];
    fits       = (upper >= dvsr);
    upper_diff = upper - dvsr;
    work_sub   = work;
    if (fits) begin
      work_sub = {upper_diff, work[WL-1:1], 1'b1};
    end
    iter_next  = iter + 1'b1;
  end

  // Controller FSM plus datapath registers; a reset discards any partial result
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      work        <= '0;
      dvsr        <= '0;
      iter        <= '0;
      busy        <= 1'b0;
      shift_en    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy     <= (state == SHIFT) || (state == SUB);
      shift_en <= (state == SHIFT);
      done     <= (state == DONE);

      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              work        <= {{WL{1'b0}}, dividend};
              dvsr        <= divisor;
              iter        <= '0;
              div_by_zero <= 1'b0;
              state       <= SHIFT;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end

        SHIFT: begin
          work  <= {work[2*WL-2:0], 1'b0};
          state <= SUB;
        end

        SUB: begin
          work <= work_sub;
          iter <= iter_next;
          if (iter_next == CW'(WL)) begin
            quotient  <= work_sub[WL-1:0];
            remainder <= work_sub[2*WL-1:WL];
            state     <= DONE;
          end else begin
            state <= SHIFT;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// tb_divider_seq_ctrl
// Scoreboard bench for divider_seq_ctrl. The driver predicts from arithmetic
// whether each start is accepted and what result it must produce. A separate
// monitor pops each expectation when done pulses and compares it with the outputs.

module tb_divider_seq_ctrl;

  localparam int WL = 4;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [WL-1:0] dividend;
  logic [WL-1:0] divisor;
  logic          busy;
  logic          shift_en;
  logic          done;
  logic [WL-1:0] quotient;
  logic [WL-1:0] remainder;
  logic          div_by_zero;

  typedef struct {
    int     q;
    int     r;
    int     dbz;
    longint due;
    int     shifts;
    int     busys;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  longint free_edge = 0;
  int     nvec = 0;
  int     nmis = 0;
  int     shift_cnt = 0;
  int     busy_cnt = 0;

  divider_seq_ctrl #(.WL(WL)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .shift_en   (shift_en),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Rising-edge counter used to time done pulses
  always @(posedge CLK) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One cycle of stimulus. A start is accepted only if the divider is back to idle by that edge.
  task automatic applyStimulus(input bit s, input logic [WL-1:0] a, input logic [WL-1:0] b);
    longint edge_k;
    exp_t   e;
    @(negedge CLK);
    start    = s;
    dividend = a;
    divisor  = b;
    edge_k   = cyc + 1;
    if (s && RST && edge_k >= free_edge) begin
      if (b == 0) begin
        e.q      = (1 << WL) - 1;
        e.r      = int'(a);
        e.dbz    = 1;
        e.due    = edge_k + 1;
        e.shifts = 0;
        e.busys  = 0;
      end else begin
        e.q      = int'(a) / int'(b);
        e.r      = int'(a) % int'(b);
        e.dbz    = 0;
        e.due    = edge_k + 2 * WL + 1;
        e.shifts = WL;
        e.busys  = 2 * WL;
      end
      sb.push_back(e);
      free_edge = e.due + 1;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, dividend, divisor);
  endtask

  // Monitor: counts strobe cycles and scores each done pulse against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        shift_cnt = 0;
        busy_cnt  = 0;
      end else begin
        if (shift_en) shift_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("quotient", 32'(quotient), e.q);
            checkOutput("remainder", 32'(remainder), e.r);
            checkOutput("div_by_zero", 32'(div_by_zero), e.dbz);
            checkOutput("done_cycle", 32'(cyc), 32'(e.due));
            checkOutput("shift_en_count", shift_cnt, e.shifts);
            checkOutput("busy_count", busy_cnt, e.busys);
            checkOutput("busy_at_done", 32'(busy), 32'd0);
          end
          shift_cnt = 0;
          busy_cnt  = 0;
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    RST      = 1'b1;
    #3 RST   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_shift_en", 32'(shift_en), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    RST = 1'b1;

    applyStimulus(1'b1, 4'd13, 4'd3);
    idleCycles(12);
    applyStimulus(1'b1, 4'd15, 4'd1);
    idleCycles(12);
    applyStimulus(1'b1, 4'd9, 4'd12);
    idleCycles(15);
    checkOutput("hold_quotient", 32'(quotient), 32'd0);
    checkOutput("hold_remainder", 32'(remainder), 32'd9);
    applyStimulus(1'b1, 4'd7, 4'd0);
    idleCycles(4);

    // Second request lands in the SUB cycle of iteration 2 and must be ignored
    applyStimulus(1'b1, 4'd13, 4'd3);
    idleCycles(3);
    applyStimulus(1'b1, 4'd6, 4'd2);
    idleCycles(12);

    // Asynchronous reset in the middle of a SHIFT cycle
    applyStimulus(1'b1, 4'd15, 4'd15);
    idleCycles(2);
    @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    free_edge = 0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_shift_en", 32'(shift_en), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_quotient", 32'(quotient), 32'd0);
    checkOutput("midreset_remainder", 32'(remainder), 32'd0);
    checkOutput("midreset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    applyStimulus(1'b1, 4'd15, 4'd15);
    idleCycles(12);

    // start held high: back-to-back operations
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 4'd14, 4'd4);
    applyStimulus(1'b0, 4'd0, 4'd0);
    idleCycles(12);

    // Randomized traffic, including zero divisors and starts while busy
    for (int i = 0; i < 600; i++) begin
      logic [WL-1:0] a;
      logic [WL-1:0] b;
      bit            s;
      a = WL'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? '0 : WL'($urandom_range(0, 15));
      s = ($urandom_range(0, 2) == 0);
      applyStimulus(s, a, b);
    end
    applyStimulus(1'b0, 4'd0, 4'd0);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge CLK);
    checkOutput("pending_at_end", sb.size(), 32'd0);
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
